core_sequencer: RTL

//  Multi-cycle control FSM for the single-issue RV32I core. Walks each instruction through

---
 rtl/core_pkg.sv | 31 +++
 rtl/core_sequencer_seq_wait_counter.sv | 42 ++++
 rtl/core_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and sizing helpers for the multi-cycle core sequencer.
package core_pkg;

  // Instruction phase walked by the sequencer.
  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    IO,
    WB,
    HALT
  } seq_state_t;

  // Kind of MEM/IO operation captured in EXEC, so MEM and IO never look at the decoder.
  typedef enum logic [1:0] {
    OP_LOAD,
    OP_STORE,
    OP_STDIN,
    OP_STDOUT
  } seq_op_t;

  localparam int DEFAULT_RAM_READ_LATENCY = 2;
  localparam int SEQ_WAIT_W = $clog2(DEFAULT_RAM_READ_LATENCY + 1);

  // Width of a counter that has to hold values 0..lat.
  function automatic int seq_wait_w(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/core_sequencer_seq_wait_counter.sv
// Load-latency down-counter. start_i arms it; done_o is high once LAT cycles
// of MEM have been spent (the arming cycle itself is EXEC and is not counted).
module seq_wait_counter
  import core_pkg::*;
#(
  parameter int LAT = DEFAULT_RAM_READ_LATENCY
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic done_o
);

  localparam int W = seq_wait_w(LAT);
  localparam logic [W-1:0] LOAD_VAL = W'(LAT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload on start, otherwise run down to zero and stay there.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RV32I core: walks each instruction through
// FETCH/DECODE/EXEC/MEM/IO/WB and issues single-cycle strobes at the right time.
module core_sequencer
  import core_pkg::*;
#(
  parameter int RAM_READ_LATENCY = DEFAULT_RAM_READ_LATENCY,
  parameter int COUNT_WIDTH      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   imem_valid,
  input  logic                   dec_reg_write_enable,
  input  logic                   dec_ram_write_enable,
  input  logic                   dec_is_load,
  input  logic                   dec_stdin,
  input  logic                   dec_stdout_write_enable,
  input  logic                   dec_illegal,
  input  logic                   stdin_valid,
  input  logic                   stdout_ready,
  output logic                   imem_req,
  output logic                   ir_load,
  output logic                   pc_write,
  output logic                   reg_write_strobe,
  output logic                   ram_write_strobe,
  output logic                   stdin_pop,
  output logic                   stdout_valid,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] retire_count
);

  seq_state_t             state_q, state_d;
  seq_op_t                op_q, op_d;
  logic [COUNT_WIDTH-1:0] retire_q, retire_d;
  logic                   wait_start;
  logic                   wait_done;

  seq_wait_counter #(
    .LAT (RAM_READ_LATENCY)
  ) u_wait (
    .clk     (clk),
    .rst     (rst),
    .start_i (wait_start),
    .done_o  (wait_done)
  );

  // Next-state and strobe decode; strobes are forced low while rst is asserted.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d          = state_q;
    op_d             = op_q;
    retire_d         = retire_q;
    wait_start       = 1'b0;
    imem_req         = 1'b0;
    ir_load          = 1'b0;
    pc_write         = 1'b0;
    reg_write_strobe = 1'b0;
    ram_write_strobe = 1'b0;
    stdin_pop        = 1'b0;
    stdout_valid     = 1'b0;
    halted           = 1'b0;

    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_load = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        // Decoder is only trusted here and in WB; the operation kind is latched for MEM/IO.
        if (dec_illegal) begin
          state_d = HALT;
        end else if (dec_is_load) begin
          op_d       = OP_LOAD;
          wait_start = 1'b1;
          state_d    = MEM;
        end else if (dec_ram_write_enable) begin
          op_d    = OP_STORE;
          state_d = MEM;
        end else if (dec_stdin) begin
          op_d    = OP_STDIN;
          state_d = IO;
        end else if (dec_stdout_write_enable) begin
          op_d    = OP_STDOUT;
          state_d = IO;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        if (op_q == OP_STORE) begin
          ram_write_strobe = 1'b1;
          state_d          = WB;
        end else if (wait_done) begin
          state_d = WB;
        end
      end
      IO: begin
        if (op_q == OP_STDIN) begin
          if (stdin_valid) begin
            stdin_pop = 1'b1;
            state_d   = WB;
          end
        end else begin
          stdout_valid = 1'b1;
          if (stdout_ready) begin
            state_d = WB;
          end
        end
      end
      WB: begin
        reg_write_strobe = dec_reg_write_enable;
        pc_write         = 1'b1;
        retire_d         = retire_q + 1'b1;
        state_d          = FETCH;
      end
      HALT: halted = 1'b1;
      default: state_d = FETCH;
    endcase

    if (rst) begin
      imem_req         = 1'b0;
      ir_load          = 1'b0;
      pc_write         = 1'b0;
      reg_write_strobe = 1'b0;
      ram_write_strobe = 1'b0;
      stdin_pop        = 1'b0;
      stdout_valid     = 1'b0;
      halted           = 1'b0;
      wait_start       = 1'b0;
    end
  end

  // State, latched operation kind and retire counter; reset wins over any phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      op_q     <= OP_LOAD;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      retire_q <= retire_d;
    end
  end

  assign retire_count = retire_q;

endmodule
